// File: rtl/fetch_queue.sv
// fetch_queue: IF->ID instruction fetch FIFO with flush and PC back-pressure.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [31:0]                  in_pc,
   input  logic [31:0]                  in_instr,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [31:0]                  out_pc,
   output logic [31:0]                  out_instr,
   input  logic                         out_ready,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];

   logic empty;
   logic full;
   logic bypass;
   logic wr_en;
   logic rd_en;

   // handshake, bypass decision and head presentation
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == FULL);
      in_ready = ~full & ~flush;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass   = empty & in_valid & ~flush;
`else
      bypass   = 1'b0;
`endif
      rd_en     = ~empty & out_ready;
      wr_en     = in_valid & in_ready & ~(bypass & out_ready);
      out_valid = ~empty | bypass;
      out_pc    = RESET_PC;
      out_instr = 32'h0000_0000;
      if (bypass) begin
         out_pc    = in_pc;
         out_instr = in_instr;
      end else if (!empty) begin
         out_pc    = mem_q[rd_ptr_q][63:32];
         out_instr = mem_q[rd_ptr_q][31:0];
      end
      count = count_q;
   end

   // pointer and occupancy next state; flush clears like reset
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         if (wr_en && !rd_en) count_d = count_q + CW'(1);
         if (!wr_en && rd_en) count_d = count_q - CW'(1);
      end
   end

   // storage write of the accepted pair
   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_ptr_q] = {in_pc, in_instr};
   end

   // control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // entry storage, contents irrelevant after reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
